// File: rtl/nanorv32_rf_wb_arbiter_if.sv
// Writeback request/grant bundle between the ALU/LSU/MDU and the regfile write-port arbiter.
// The arbiter takes the slave side; requesters and the regfile sink take the master side.
interface nanorv32_rf_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              stall;

    logic              alu_valid;
    logic [REG_AW-1:0] alu_sel_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              lsu_valid;
    logic [REG_AW-1:0] lsu_sel_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              lsu_ready;

    logic              mdu_valid;
    logic [REG_AW-1:0] mdu_sel_rd;
    logic [DATA_W-1:0] mdu_data;
    logic              mdu_ready;

    logic [REG_AW-1:0] sel_rd;
    logic [DATA_W-1:0] rd;
    logic              write_rd;
    logic [REG_AW-1:0] sel_rd2;
    logic [DATA_W-1:0] rd2;
    logic              write_rd2;

    modport slave (
        input  stall,
        input  alu_valid, alu_sel_rd, alu_data,
        input  lsu_valid, lsu_sel_rd, lsu_data,
        input  mdu_valid, mdu_sel_rd, mdu_data,
        output alu_ready, lsu_ready, mdu_ready,
        output sel_rd, rd, write_rd, sel_rd2, rd2, write_rd2
    );

    modport master (
        output stall,
        output alu_valid, alu_sel_rd, alu_data,
        output lsu_valid, lsu_sel_rd, lsu_data,
        output mdu_valid, mdu_sel_rd, mdu_data,
        input  alu_ready, lsu_ready, mdu_ready,
        input  sel_rd, rd, write_rd, sel_rd2, rd2, write_rd2
    );
endinterface

// File: rtl/nanorv32_rf_wb_arbiter.sv
// Grants up to two of ALU/LSU/MDU per cycle onto the regfile ports, 1-cycle registered; stall, port or dest conflict holds ready low.
// NANORV32_RF_WB_STARVE_EN adds per-requester wait counters that promote a requester after STARVE_LIMIT waits.
module nanorv32_rf_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 5,
    parameter int STARVE_LIMIT = 7,
    parameter int CNT_W        = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    nanorv32_rf_wb_arbiter_if.slave  bus
);
    localparam int NR = 3;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT >= (1 << CNT_W)) begin : g_bad_limit
        $error("STARVE_LIMIT must fit in CNT_W bits and be nonzero");
    end

    // Index 0 = alu, 1 = lsu, 2 = mdu: index order is the base priority.
    logic [NR-1:0]     req_vld;
    logic [REG_AW-1:0] req_sel [NR];
    logic [DATA_W-1:0] req_dat [NR];

    assign req_vld    = {bus.mdu_valid, bus.lsu_valid, bus.alu_valid};
    assign req_sel[0] = bus.alu_sel_rd;
    assign req_sel[1] = bus.lsu_sel_rd;
    assign req_sel[2] = bus.mdu_sel_rd;
    assign req_dat[0] = bus.alu_data;
    assign req_dat[1] = bus.lsu_data;
    assign req_dat[2] = bus.mdu_data;

    logic [NR-1:0]     prom;
    logic [NR-1:0]     gnt_rdy;
    logic              p1_vld, p2_vld;
    logic [REG_AW-1:0] p1_sel, p2_sel;
    logic [DATA_W-1:0] p1_dat, p2_dat;

    // Two passes over the base order: promoted requesters first, then the rest.
    always_comb begin
        gnt_rdy = '0;
        p1_vld  = 1'b0;
        p2_vld  = 1'b0;
        p1_sel  = '0;
        p2_sel  = '0;
        p1_dat  = '0;
        p2_dat  = '0;
        if (!rst && !bus.stall) begin
            for (int pass = 0; pass < 2; pass++) begin
                for (int i = 0; i < NR; i++) begin
                    if (req_vld[i] && (prom[i] == (pass == 0))) begin
                        if (req_sel[i] == '0) begin
                            gnt_rdy[i] = 1'b1;
                        end else if (!p1_vld) begin
                            p1_vld     = 1'b1;
                            p1_sel     = req_sel[i];
                            p1_dat     = req_dat[i];
                            gnt_rdy[i] = 1'b1;
                        end else if (!p2_vld && (req_sel[i] != p1_sel)) begin
                            p2_vld     = 1'b1;
                            p2_sel     = req_sel[i];
                            p2_dat     = req_dat[i];
                            gnt_rdy[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

`ifdef NANORV32_RF_WB_STARVE_EN
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q [NR];
    logic [CNT_W-1:0] cnt_d [NR];

    // Counters stop at LIMIT so a promoted requester stays promoted until granted.
    always_comb begin
        for (int i = 0; i < NR; i++) begin
            prom[i]  = (cnt_q[i] == LIMIT);
            cnt_d[i] = cnt_q[i];
            if (!req_vld[i] || gnt_rdy[i]) begin
                cnt_d[i] = '0;
            end else if (!bus.stall && (cnt_q[i] != LIMIT)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    assign prom = '0;
`endif

    logic [REG_AW-1:0] sel_rd_q,   sel_rd_d;
    logic [DATA_W-1:0] rd_q,       rd_d;
    logic              write_rd_q, write_rd_d;
    logic [REG_AW-1:0] sel_rd2_q,  sel_rd2_d;
    logic [DATA_W-1:0] rd2_q,      rd2_d;
    logic              write_rd2_q, write_rd2_d;

    // Index/data hold their last value when the port is idle; only the strobe drops.
    always_comb begin
        sel_rd_d    = sel_rd_q;
        rd_d        = rd_q;
        write_rd_d  = p1_vld;
        sel_rd2_d   = sel_rd2_q;
        rd2_d       = rd2_q;
        write_rd2_d = p2_vld;
        if (p1_vld) begin
            sel_rd_d = p1_sel;
            rd_d     = p1_dat;
        end
        if (p2_vld) begin
            sel_rd2_d = p2_sel;
            rd2_d     = p2_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_rd_q    <= '0;
            rd_q        <= '0;
            write_rd_q  <= 1'b0;
            sel_rd2_q   <= '0;
            rd2_q       <= '0;
            write_rd2_q <= 1'b0;
        end else begin
            sel_rd_q    <= sel_rd_d;
            rd_q        <= rd_d;
            write_rd_q  <= write_rd_d;
            sel_rd2_q   <= sel_rd2_d;
            rd2_q       <= rd2_d;
            write_rd2_q <= write_rd2_d;
        end
    end

    assign bus.alu_ready = gnt_rdy[0];
    assign bus.lsu_ready = gnt_rdy[1];
    assign bus.mdu_ready = gnt_rdy[2];
    assign bus.sel_rd    = sel_rd_q;
    assign bus.rd        = rd_q;
    assign bus.write_rd  = write_rd_q;
    assign bus.sel_rd2   = sel_rd2_q;
    assign bus.rd2       = rd2_q;
    assign bus.write_rd2 = write_rd2_q;
endmodule
